// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter_pkg
// Purpose  : Shared FSM encoding and width helper for the frequency meter.
// Revision : 1.0 - initial release
// ============================================================================
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATE   = 2'd1,
        REPORT = 2'd2
    } state_t;

    // Bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((longint'(1) << r) < longint'(value)) begin
            r++;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_det
// Purpose  : 2-FF synchronizer plus rising-edge detector for async inputs.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign rise = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/clk_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : clk_freq_meter
// Purpose  : Counts rising edges of an async signal over a fixed gate window.
// Revision : 1.0 - initial release
// ============================================================================
module clk_freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 50000,
    parameter int CNT_W       = 16,
    parameter int MIN_CNT     = 0,
    parameter int MAX_CNT     = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_cnt,
    output logic             cnt_valid,
    output logic             in_range,
    output logic             overflow,
    output logic             busy
);

    localparam int                    c_gate_w    = clog2(GATE_CYCLES);
    localparam logic [c_gate_w-1:0]   c_gate_last = c_gate_w'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      c_cnt_max   = '1;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_gate_w-1:0] r_gate_cnt;
    logic [CNT_W-1:0]    r_edge_cnt;
    logic                r_ovf;
    logic                w_rise;
    logic                w_clear;
    logic                w_count;
    logic                w_load;
    logic                w_sat;
    logic [CNT_W-1:0]    w_edge_next;
    logic                w_ovf_next;
    logic                w_ge_min;
    logic                w_le_max;

    sync_edge_det u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sig_in),
        .rise  (w_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_count      = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_clear      = 1'b1;
                    w_state_next = GATE;
                end
            end
            GATE: begin
                if (!enable) begin
                    w_state_next = IDLE;
                end else begin
                    w_count = 1'b1;
                    if (r_gate_cnt == c_gate_last) begin
                        w_load       = 1'b1;
                        w_state_next = REPORT;
                    end
                end
            end
            REPORT: begin
                if (enable) begin
                    w_clear      = 1'b1;
                    w_state_next = GATE;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The result is loaded from the next-count value so the final gate
    // cycle's edge is included and the outputs are fresh during REPORT.
    assign w_sat       = (r_edge_cnt == c_cnt_max);
    assign w_edge_next = (w_rise && !w_sat) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
    assign w_ovf_next  = r_ovf | (w_rise & w_sat);

    generate
        if (MIN_CNT <= 0) begin : g_min_open
            assign w_ge_min = 1'b1;
        end else begin : g_min_cmp
            assign w_ge_min = (w_edge_next >= CNT_W'(MIN_CNT));
        end
        if (longint'(MAX_CNT) >= (longint'(1) << CNT_W) - 1) begin : g_max_open
            assign w_le_max = 1'b1;
        end else begin : g_max_cmp
            assign w_le_max = (w_edge_next <= CNT_W'(MAX_CNT));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
        end else if (w_clear) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
        end else if (w_count) begin
            r_gate_cnt <= r_gate_cnt + c_gate_w'(1);
            r_edge_cnt <= w_edge_next;
            r_ovf      <= w_ovf_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_cnt <= '0;
            overflow <= 1'b0;
            in_range <= 1'b0;
        end else if (w_load) begin
            freq_cnt <= w_edge_next;
            overflow <= w_ovf_next;
            in_range <= w_ge_min & w_le_max & ~w_ovf_next;
        end
    end

    assign cnt_valid = (r_state == REPORT);
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_clk_freq_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_clk_freq_meter
// Purpose  : Scoreboard bench; two meter instances (16-bit and 6-bit counter).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_freq_meter;

    localparam int GATE  = 1000;
    localparam int MIN16 = 200;
    localparam int MAX16 = 300;

    typedef struct {
        int lo;
        int hi;
        bit ovf;
        bit inr;
        int at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        sig_sync = 1'b0;
    logic        sig_async = 1'b0;
    logic        async_mode = 1'b0;
    logic        sig_in;
    logic [15:0] freq16;
    logic        val16, inr16, ovf16, busy16;
    logic [5:0]  freq6;
    logic        val6, inr6, ovf6, busy6;

    int   errors = 0;
    int   checks = 0;
    int   edge_n = 0;
    bit   hist [0:131071];
    exp_t q16[$];
    exp_t q6[$];
    exp_t last16 = '{0, 0, 1'b0, 1'b0, 0};
    exp_t last6  = '{0, 0, 1'b0, 1'b0, 0};
    bit   win_active = 1'b0;
    int   win_s = 0;

    int   g_hold = 1, g_hold_val = 0;
    int   hi_min = 2, hi_max = 2, lo_min = 2, lo_max = 2;
    bit   gen_level = 1'b0;
    int   gen_left = 0;

    assign sig_in = async_mode ? sig_async : sig_sync;

    clk_freq_meter #(.GATE_CYCLES(GATE), .CNT_W(16), .MIN_CNT(MIN16), .MAX_CNT(MAX16)) dut16 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
        .freq_cnt(freq16), .cnt_valid(val16), .in_range(inr16), .overflow(ovf16), .busy(busy16)
    );

    clk_freq_meter #(.GATE_CYCLES(GATE), .CNT_W(6), .MIN_CNT(0), .MAX_CNT(65535)) dut6 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
        .freq_cnt(freq6), .cnt_valid(val6), .in_range(inr6), .overflow(ovf6), .busy(busy6)
    );

    always #10 clk = ~clk;
    always @(posedge clk) edge_n++;

    // Free-running async source: period 7.3 clk, phase off the clock grid.
    initial begin
        #($urandom_range(0, 145));
        #0.5;
        forever #73 sig_async = ~sig_async;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", edge_n);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, edge_n);
        end
    endtask

    // Reference: saturate the raw edge count to the counter width, then flag.
    function automatic exp_t model(input int raw_lo, input int raw_hi, input int w,
                                   input int mn, input int mx, input int at);
        exp_t e;
        int   top;
        top   = (1 << w) - 1;
        e.lo  = (raw_lo > top) ? top : raw_lo;
        e.hi  = (raw_hi > top) ? top : raw_hi;
        e.ovf = (raw_lo > top);
        e.inr = !e.ovf && (e.lo >= mn) && (e.lo <= mx);
        e.at  = at;
        return e;
    endfunction

    // A window started by enable seen at sample s counts 0->1 transitions of
    // the sampled input at samples s .. s+GATE-1; strobe appears at s+GATE+1.
    task automatic push_expected();
        int raw_lo, raw_hi;
        if (async_mode) begin
            raw_lo = 136;
            raw_hi = 138;
        end else begin
            raw_lo = 0;
            for (int k = win_s; k < win_s + GATE; k++)
                if (hist[k] && !hist[k-1]) raw_lo++;
            raw_hi = raw_lo;
        end
        q16.push_back(model(raw_lo, raw_hi, 16, MIN16, MAX16, win_s + GATE + 1));
        q6.push_back(model(raw_lo, raw_hi, 6, 0, 63, win_s + GATE + 1));
    endtask

    task automatic drive_cycle();
        bit v;
        @(negedge clk);
        if (!rst_n) begin
            v = 1'b0;
            gen_level = 1'b0;
            gen_left = 0;
        end else if (g_hold != 0) begin
            v = g_hold_val[0];
        end else begin
            if (gen_left == 0) begin
                gen_level = !gen_level;
                gen_left = gen_level ? int'($urandom_range(hi_max, hi_min))
                                     : int'($urandom_range(lo_max, lo_min));
            end
            v = gen_level;
            gen_left--;
        end
        sig_sync = v;
        hist[edge_n + 1] = v;
        if (win_active && (edge_n + 1 == win_s + GATE - 1)) begin
            push_expected();
            win_s += GATE + 1;
        end
    endtask

    task automatic set_gen(input int hold, input int hval, input int hmin, input int hmax,
                           input int lmin, input int lmax);
        g_hold = hold; g_hold_val = hval;
        hi_min = hmin; hi_max = hmax; lo_min = lmin; lo_max = lmax;
        gen_level = sig_sync;
        gen_left = 0;
    endtask

    task automatic start_enable();
        enable = 1'b1;
        win_active = 1'b1;
        win_s = edge_n;
    endtask

    task automatic stop_enable();
        enable = 1'b0;
        win_active = 1'b0;
    endtask

    task automatic align();
        int guard;
        guard = 0;
        while ((edge_n + 1 != win_s) && guard < 3000) begin
            drive_cycle();
            guard++;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " d16 freq_cnt"}, freq16, 0, 0);
        chk({tag, " d16 cnt_valid"}, val16, 0, 0);
        chk({tag, " d16 in_range"}, inr16, 0, 0);
        chk({tag, " d16 overflow"}, ovf16, 0, 0);
        chk({tag, " d16 busy"}, busy16, 0, 0);
        chk({tag, " d6 freq_cnt"}, freq6, 0, 0);
        chk({tag, " d6 cnt_valid"}, val6, 0, 0);
        chk({tag, " d6 in_range"}, inr6, 0, 0);
        chk({tag, " d6 overflow"}, ovf6, 0, 0);
        chk({tag, " d6 busy"}, busy6, 0, 0);
    endtask

    task automatic check_hold(input string tag);
        chk({tag, " d16 freq_cnt hold"}, freq16, last16.lo, last16.hi);
        chk({tag, " d16 in_range hold"}, inr16, last16.inr, last16.inr);
        chk({tag, " d16 overflow hold"}, ovf16, last16.ovf, last16.ovf);
        chk({tag, " d6 freq_cnt hold"}, freq6, last6.lo, last6.hi);
        chk({tag, " d6 overflow hold"}, ovf6, last6.ovf, last6.ovf);
    endtask

    task automatic cmp_win(input string tag, input exp_t e, input int cnt,
                           input bit inr, input bit ovf, input bit bsy);
        chk({tag, " freq_cnt"}, cnt, e.lo, e.hi);
        chk({tag, " in_range"}, inr, e.inr, e.inr);
        chk({tag, " overflow"}, ovf, e.ovf, e.ovf);
        chk({tag, " strobe cycle"}, edge_n, e.at, e.at);
        chk({tag, " busy in report"}, bsy, 1, 1);
    endtask

    // Monitor: pops one expectation per strobe, independent of the stimulus.
    always @(negedge clk) begin
        exp_t e;
        if (val16) begin
            if (q16.size() == 0) begin
                checks++; errors++;
                $display("FAIL d16 unexpected cnt_valid: got strobe, expected none (cycle %0d)", edge_n);
            end else begin
                e = q16.pop_front();
                last16 = e;
                cmp_win("d16", e, int'(freq16), inr16, ovf16, busy16);
            end
        end
        if (val6) begin
            if (q6.size() == 0) begin
                checks++; errors++;
                $display("FAIL d6 unexpected cnt_valid: got strobe, expected none (cycle %0d)", edge_n);
            end else begin
                e = q6.pop_front();
                last6 = e;
                cmp_win("d6", e, int'(freq6), inr6, ovf6, busy6);
            end
        end
    end

    initial begin
        set_gen(1, 0, 2, 2, 2, 2);
        repeat (4) drive_cycle();
        check_zero("reset");
        rst_n = 1'b1;
        repeat (6) drive_cycle();

        // Continuous period-4 input from the first window on.
        set_gen(0, 0, 2, 2, 2, 2);
        repeat (9) drive_cycle();
        start_enable();
        drive_cycle();
        chk("busy after enable", busy16, 1, 1);
        repeat (3 * (GATE + 1)) drive_cycle();

        // Window-aligned patterns: static levels, slow/fast periods, random.
        for (int w = 0; w < 10; w++) begin
            align();
            case (w)
                0, 1:    set_gen(1, 0, 2, 2, 2, 2);
                2, 3:    set_gen(1, 1, 2, 2, 2, 2);
                4, 5:    set_gen(0, 0, 20, 20, 20, 20);
                6:       set_gen(0, 0, 2, 2, 2, 2);
                default: set_gen(0, 0, 2, int'($urandom_range(30, 2)), 2, int'($urandom_range(30, 2)));
            endcase
            repeat (GATE + 1) drive_cycle();
        end

        // Abort mid-window, then restart.
        align();
        repeat (500) drive_cycle();
        chk("busy before abort", busy16, 1, 1);
        stop_enable();
        drive_cycle();
        chk("d16 busy after abort", busy16, 0, 0);
        chk("d6 busy after abort", busy6, 0, 0);
        check_hold("abort");
        repeat (20) drive_cycle();
        check_hold("idle");
        start_enable();
        repeat (2 * (GATE + 1) + 5) drive_cycle();

        // Asynchronous reset mid-gate, released with enable still high.
        align();
        repeat (300) drive_cycle();
        #3;
        rst_n = 1'b0;
        win_active = 1'b0;
        #1;
        check_zero("async reset");
        last16 = '{0, 0, 1'b0, 1'b0, 0};
        last6  = '{0, 0, 1'b0, 1'b0, 0};
        repeat (5) drive_cycle();
        rst_n = 1'b1;
        win_active = 1'b1;
        win_s = edge_n;
        repeat (2 * (GATE + 1) + 5) drive_cycle();

        // Asynchronous 7.3-cycle input for 20 windows.
        align();
        repeat (500) drive_cycle();
        stop_enable();
        set_gen(1, 0, 2, 2, 2, 2);
        repeat (5) drive_cycle();
        async_mode = 1'b1;
        repeat (20) drive_cycle();
        start_enable();
        repeat (20 * (GATE + 1) + 3) drive_cycle();
        repeat (500) drive_cycle();
        stop_enable();
        repeat (10) drive_cycle();

        chk("d16 pending strobes", q16.size(), 0, 0);
        chk("d6 pending strobes", q6.size(), 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
